tile_run_controller: RTL and testbench

- Synthesizable run controller for 1..N Tile instances; generalises the bench-only reset/run/finish sequence into RTL.
- Holds tiles in reset, releases them, counts run cycles, and collects per-tile done flags and exit codes.
- Reports pass, fail or timeout.
- Sits beside the Tile array in the FPGA top and in regression benches; also usable as a hardware self-test sequencer.

---
 rtl/tile_run_controller.sv | 142 ++++++++++++++
 tb/tb_tile_run_controller.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tile_run_controller.sv
// tile_run_controller
//   Sequences a run of NUM_TILES tiles: it holds them in reset, releases them,
//   counts run cycles, collects per-tile done flags and exit codes, and reports
//   pass, fail or timeout.
//
// Ports
//   clock          single clock
//   reset          synchronous, active-low reset
//   io_start       single-cycle start/restart request (honoured in IDLE and DONE)
//   io_tile_done   per-tile done strobe or level (sampled in RUN only)
//   io_tile_code   per-tile exit code; tile i at [i*CODE_W +: CODE_W]
//   io_tile_reset  active-high reset to each tile
//   io_busy        high in RESET or RUN
//   io_finished    high in DONE
//   io_pass        all tiles done, none failed, no timeout (valid in DONE)
//   io_timeout     run ended by timeout
//   io_done_mask   sticky per-tile done
//   io_fail_mask   tile reported a nonzero exit code on its first done
//   io_cycles      RUN cycles elapsed in the current/last run
module tile_run_controller #(
    parameter int NUM_TILES      = 1,
    parameter int RESET_CYCLES   = 2,
    parameter int TIMEOUT_CYCLES = 100,
    parameter int CNT_W          = 32,
    parameter int CODE_W         = 8
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        io_start,
    input  logic [NUM_TILES-1:0]        io_tile_done,
    input  logic [NUM_TILES*CODE_W-1:0] io_tile_code,
    output logic [NUM_TILES-1:0]        io_tile_reset,
    output logic                        io_busy,
    output logic                        io_finished,
    output logic                        io_pass,
    output logic                        io_timeout,
    output logic [NUM_TILES-1:0]        io_done_mask,
    output logic [NUM_TILES-1:0]        io_fail_mask,
    output logic [CNT_W-1:0]            io_cycles
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RESET,
        ST_RUN,
        ST_DONE
    } state_t;

    localparam logic [CNT_W-1:0] TIMEOUT_LIMIT = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [31:0]      RST_LAST      = 32'(RESET_CYCLES - 1);

    state_t          state;
    logic [31:0]     rst_cnt;

    logic [NUM_TILES-1:0] new_done;
    logic [NUM_TILES-1:0] code_nz;
    logic [NUM_TILES-1:0] next_done;
    logic [NUM_TILES-1:0] next_fail;
    logic                 all_done;
    logic                 timeout_hit;
    logic [CNT_W-1:0]     cycles_inc;

    // Only the first done of each tile captures its exit code.
    always_comb begin
        code_nz = '0;
        for (int unsigned i = 0; i < NUM_TILES; i++) begin
            code_nz[i] = |io_tile_code[i*CODE_W +: CODE_W];
        end
        new_done    = io_tile_done & ~io_done_mask;
        next_done   = io_done_mask | io_tile_done;
        next_fail   = (io_fail_mask & ~new_done) | (code_nz & new_done);
        all_done    = &next_done;
        cycles_inc  = io_cycles + CNT_W'(1);
        timeout_hit = (cycles_inc == TIMEOUT_LIMIT);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state         <= ST_IDLE;
            rst_cnt       <= '0;
            io_tile_reset <= '1;
            io_busy       <= 1'b0;
            io_finished   <= 1'b0;
            io_pass       <= 1'b0;
            io_timeout    <= 1'b0;
            io_done_mask  <= '0;
            io_fail_mask  <= '0;
            io_cycles     <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    io_tile_reset <= '1;
                    if (io_start) begin
                        state        <= ST_RESET;
                        rst_cnt      <= '0;
                        io_busy      <= 1'b1;
                        io_finished  <= 1'b0;
                        io_pass      <= 1'b0;
                        io_timeout   <= 1'b0;
                        io_done_mask <= '0;
                        io_fail_mask <= '0;
                        io_cycles    <= '0;
                    end
                end
                ST_RESET: begin
                    rst_cnt <= rst_cnt + 32'd1;
                    if (rst_cnt == RST_LAST) begin
                        state         <= ST_RUN;
                        io_tile_reset <= '0;
                    end
                end
                ST_RUN: begin
                    io_cycles    <= cycles_inc;
                    io_done_mask <= next_done;
                    io_fail_mask <= next_fail;
                    // Registered copy of the new mask re-holds a finished tile
                    // from the cycle after its done is captured.
                    io_tile_reset <= next_done;
                    if (all_done) begin
                        state         <= ST_DONE;
                        io_tile_reset <= '1;
                        io_busy       <= 1'b0;
                        io_finished   <= 1'b1;
                        io_timeout    <= 1'b0;
                        io_pass       <= ~|next_fail;
                    end else if (timeout_hit) begin
                        state         <= ST_DONE;
                        io_tile_reset <= '1;
                        io_busy       <= 1'b0;
                        io_finished   <= 1'b1;
                        io_timeout    <= 1'b1;
                        io_pass       <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tile_run_controller.sv
// tb_tile_run_controller
//   Directed bench for tile_run_controller using three instances:
//   u1 (1 tile), u4 (4 tiles), u2 (2 tiles), all with RESET_CYCLES=2 and
//   TIMEOUT_CYCLES=100. Inputs change and outputs are sampled 1 time unit
//   after each rising clock edge.
module tb_tile_run_controller;

    logic clock;
    logic reset;

    logic        start1, done1;
    logic [7:0]  code1;
    logic        trst1;
    logic        busy1, fin1, pass1, tout1;
    logic        dmask1, fmask1;
    logic [31:0] cyc1;

    logic        start4;
    logic [3:0]  done4;
    logic [31:0] code4;
    logic [3:0]  trst4, dmask4, fmask4;
    logic        busy4, fin4, pass4, tout4;
    logic [31:0] cyc4;

    logic        start2;
    logic [1:0]  done2;
    logic [15:0] code2;
    logic [1:0]  trst2, dmask2, fmask2;
    logic        busy2, fin2, pass2, tout2;
    logic [31:0] cyc2;

    int passed;
    int total;

    tile_run_controller #(.NUM_TILES(1), .RESET_CYCLES(2), .TIMEOUT_CYCLES(100), .CNT_W(32), .CODE_W(8)) u1 (
        .clock(clock), .reset(reset), .io_start(start1), .io_tile_done(done1), .io_tile_code(code1),
        .io_tile_reset(trst1), .io_busy(busy1), .io_finished(fin1), .io_pass(pass1), .io_timeout(tout1),
        .io_done_mask(dmask1), .io_fail_mask(fmask1), .io_cycles(cyc1)
    );

    tile_run_controller #(.NUM_TILES(4), .RESET_CYCLES(2), .TIMEOUT_CYCLES(100), .CNT_W(32), .CODE_W(8)) u4 (
        .clock(clock), .reset(reset), .io_start(start4), .io_tile_done(done4), .io_tile_code(code4),
        .io_tile_reset(trst4), .io_busy(busy4), .io_finished(fin4), .io_pass(pass4), .io_timeout(tout4),
        .io_done_mask(dmask4), .io_fail_mask(fmask4), .io_cycles(cyc4)
    );

    tile_run_controller #(.NUM_TILES(2), .RESET_CYCLES(2), .TIMEOUT_CYCLES(100), .CNT_W(32), .CODE_W(8)) u2 (
        .clock(clock), .reset(reset), .io_start(start2), .io_tile_done(done2), .io_tile_code(code2),
        .io_tile_reset(trst2), .io_busy(busy2), .io_finished(fin2), .io_pass(pass2), .io_timeout(tout2),
        .io_done_mask(dmask2), .io_fail_mask(fmask2), .io_cycles(cyc2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) step();
        total++; if (trst1 !== 1'b1) $display("FAIL rst_trst1: got %0h want 1", trst1); else passed++;
        total++; if (trst4 !== 4'hF) $display("FAIL rst_trst4: got %0h want f", trst4); else passed++;
        total++; if (cyc1 !== 32'd0) $display("FAIL rst_cyc1: got %0d want 0", cyc1); else passed++;
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            total++; if (trst1 !== 1'b1) $display("FAIL idle_trst[%0d]: got %0h want 1", i, trst1); else passed++;
            total++; if (busy1 !== 1'b0) $display("FAIL idle_busy[%0d]: got %0h want 0", i, busy1); else passed++;
            total++; if (fin1 !== 1'b0) $display("FAIL idle_fin[%0d]: got %0h want 0", i, fin1); else passed++;
            total++; if (cyc1 !== 32'd0) $display("FAIL idle_cyc[%0d]: got %0d want 0", i, cyc1); else passed++;
        end
    endtask

    task automatic test_single();
        start1 = 1'b1;
        step();
        start1 = 1'b0;
        // done during RESET must not be captured
        done1 = 1'b1;
        code1 = 8'h55;
        total++; if (trst1 !== 1'b1) $display("FAIL single_trst_r1: got %0h want 1", trst1); else passed++;
        total++; if (busy1 !== 1'b1) $display("FAIL single_busy_r1: got %0h want 1", busy1); else passed++;
        step();
        total++; if (trst1 !== 1'b1) $display("FAIL single_trst_r2: got %0h want 1", trst1); else passed++;
        done1 = 1'b0;
        code1 = 8'h00;
        step();
        total++; if (trst1 !== 1'b0) $display("FAIL single_release: got %0h want 0", trst1); else passed++;
        total++; if (dmask1 !== 1'b0) $display("FAIL single_reset_done_ignored: got %0h want 0", dmask1); else passed++;
        total++; if (cyc1 !== 32'd0) $display("FAIL single_cyc_start: got %0d want 0", cyc1); else passed++;
        repeat (4) step();
        total++; if (cyc1 !== 32'd4) $display("FAIL single_cyc4: got %0d want 4", cyc1); else passed++;
        total++; if (fin1 !== 1'b0) $display("FAIL single_fin_early: got %0h want 0", fin1); else passed++;
        done1 = 1'b1;
        step();
        done1 = 1'b0;
        total++; if (fin1 !== 1'b1) $display("FAIL single_fin: got %0h want 1", fin1); else passed++;
        total++; if (busy1 !== 1'b0) $display("FAIL single_busy_end: got %0h want 0", busy1); else passed++;
        total++; if (cyc1 !== 32'd5) $display("FAIL single_cyc: got %0d want 5", cyc1); else passed++;
        total++; if (pass1 !== 1'b1) $display("FAIL single_pass: got %0h want 1", pass1); else passed++;
        total++; if (tout1 !== 1'b0) $display("FAIL single_tout: got %0h want 0", tout1); else passed++;
        total++; if (fmask1 !== 1'b0) $display("FAIL single_fmask: got %0h want 0", fmask1); else passed++;
        total++; if (dmask1 !== 1'b1) $display("FAIL single_dmask: got %0h want 1", dmask1); else passed++;
        total++; if (trst1 !== 1'b1) $display("FAIL single_trst_done: got %0h want 1", trst1); else passed++;
    endtask

    task automatic test_multi();
        logic [3:0] exp_rst;
        logic [7:0] c0;
        logic [7:0] c1;
        logic [7:0] c2;
        logic [7:0] c3;
        start4 = 1'b1;
        step();
        start4 = 1'b0;
        step();
        step();
        total++; if (trst4 !== 4'h0) $display("FAIL multi_release: got %0h want 0", trst4); else passed++;
        for (int c = 1; c <= 9; c++) begin
            // tile 0 holds done as a level; its later nonzero code must be ignored
            done4[0] = (c >= 3);
            done4[1] = (c == 7);
            done4[2] = (c == 7);
            done4[3] = (c == 9);
            c0 = (c == 3) ? 8'h00 : 8'hFF;
            c1 = (c == 7) ? 8'h00 : 8'h77;
            c2 = (c == 7) ? 8'h2A : 8'h77;
            c3 = (c == 9) ? 8'h00 : 8'h77;
            code4 = {c3, c2, c1, c0};
            step();
            if (c < 9) begin
                exp_rst = 4'h0;
                if (c >= 3) exp_rst = exp_rst | 4'b0001;
                if (c >= 7) exp_rst = exp_rst | 4'b0110;
                total++; if (trst4 !== exp_rst) $display("FAIL multi_trst[c%0d]: got %0h want %0h", c, trst4, exp_rst); else passed++;
                total++; if (fin4 !== 1'b0) $display("FAIL multi_fin_early[c%0d]: got %0h want 0", c, fin4); else passed++;
            end
        end
        done4 = 4'h0;
        code4 = 32'h0;
        total++; if (fin4 !== 1'b1) $display("FAIL multi_fin: got %0h want 1", fin4); else passed++;
        total++; if (cyc4 !== 32'd9) $display("FAIL multi_cyc: got %0d want 9", cyc4); else passed++;
        total++; if (fmask4 !== 4'b0100) $display("FAIL multi_fmask: got %0h want 4", fmask4); else passed++;
        total++; if (dmask4 !== 4'hF) $display("FAIL multi_dmask: got %0h want f", dmask4); else passed++;
        total++; if (pass4 !== 1'b0) $display("FAIL multi_pass: got %0h want 0", pass4); else passed++;
        total++; if (tout4 !== 1'b0) $display("FAIL multi_tout: got %0h want 0", tout4); else passed++;
        total++; if (trst4 !== 4'hF) $display("FAIL multi_trst_done: got %0h want f", trst4); else passed++;
    endtask

    task automatic test_timeout();
        start2 = 1'b1;
        step();
        start2 = 1'b0;
        step();
        step();
        done2 = 2'b01;
        code2 = 16'h0000;
        step();
        done2 = 2'b00;
        total++; if (dmask2 !== 2'b01) $display("FAIL tout_dmask_early: got %0h want 1", dmask2); else passed++;
        total++; if (trst2 !== 2'b01) $display("FAIL tout_trst: got %0h want 1", trst2); else passed++;
        repeat (98) step();
        total++; if (fin2 !== 1'b0) $display("FAIL tout_fin_early: got %0h want 0", fin2); else passed++;
        total++; if (cyc2 !== 32'd99) $display("FAIL tout_cyc99: got %0d want 99", cyc2); else passed++;
        step();
        total++; if (fin2 !== 1'b1) $display("FAIL tout_fin: got %0h want 1", fin2); else passed++;
        total++; if (tout2 !== 1'b1) $display("FAIL tout_flag: got %0h want 1", tout2); else passed++;
        total++; if (dmask2 !== 2'b01) $display("FAIL tout_dmask: got %0h want 1", dmask2); else passed++;
        total++; if (pass2 !== 1'b0) $display("FAIL tout_pass: got %0h want 0", pass2); else passed++;
        total++; if (cyc2 !== 32'd100) $display("FAIL tout_cyc: got %0d want 100", cyc2); else passed++;
    endtask

    task automatic test_done_at_limit();
        // restart straight from DONE
        start2 = 1'b1;
        step();
        start2 = 1'b0;
        total++; if (busy2 !== 1'b1) $display("FAIL restart_busy: got %0h want 1", busy2); else passed++;
        total++; if (fin2 !== 1'b0) $display("FAIL restart_fin: got %0h want 0", fin2); else passed++;
        total++; if (tout2 !== 1'b0) $display("FAIL restart_tout: got %0h want 0", tout2); else passed++;
        total++; if (dmask2 !== 2'b00) $display("FAIL restart_dmask: got %0h want 0", dmask2); else passed++;
        total++; if (cyc2 !== 32'd0) $display("FAIL restart_cyc: got %0d want 0", cyc2); else passed++;
        step();
        step();
        done2 = 2'b01;
        step();
        done2 = 2'b00;
        repeat (98) step();
        total++; if (cyc2 !== 32'd99) $display("FAIL limit_cyc99: got %0d want 99", cyc2); else passed++;
        done2 = 2'b10;
        step();
        done2 = 2'b00;
        total++; if (fin2 !== 1'b1) $display("FAIL limit_fin: got %0h want 1", fin2); else passed++;
        total++; if (tout2 !== 1'b0) $display("FAIL limit_tout: got %0h want 0", tout2); else passed++;
        total++; if (pass2 !== 1'b1) $display("FAIL limit_pass: got %0h want 1", pass2); else passed++;
        total++; if (cyc2 !== 32'd100) $display("FAIL limit_cyc: got %0d want 100", cyc2); else passed++;
        total++; if (dmask2 !== 2'b11) $display("FAIL limit_dmask: got %0h want 3", dmask2); else passed++;
    endtask

    task automatic test_abort_and_rerun();
        start1 = 1'b1;
        step();
        start1 = 1'b0;
        step();
        step();
        repeat (39) step();
        total++; if (cyc1 !== 32'd39) $display("FAIL abort_cyc39: got %0d want 39", cyc1); else passed++;
        total++; if (busy1 !== 1'b1) $display("FAIL abort_busy_pre: got %0h want 1", busy1); else passed++;
        reset = 1'b0;
        step();
        reset = 1'b1;
        total++; if (busy1 !== 1'b0) $display("FAIL abort_busy: got %0h want 0", busy1); else passed++;
        total++; if (fin1 !== 1'b0) $display("FAIL abort_fin: got %0h want 0", fin1); else passed++;
        total++; if (trst1 !== 1'b1) $display("FAIL abort_trst: got %0h want 1", trst1); else passed++;
        total++; if (cyc1 !== 32'd0) $display("FAIL abort_cyc: got %0d want 0", cyc1); else passed++;
        total++; if (dmask1 !== 1'b0) $display("FAIL abort_dmask: got %0h want 0", dmask1); else passed++;
        total++; if (pass1 !== 1'b0) $display("FAIL abort_pass: got %0h want 0", pass1); else passed++;
        total++; if (tout1 !== 1'b0) $display("FAIL abort_tout: got %0h want 0", tout1); else passed++;
        step();
        start1 = 1'b1;
        step();
        start1 = 1'b0;
        step();
        step();
        step();
        // start pulse in RUN must be ignored
        start1 = 1'b1;
        step();
        start1 = 1'b0;
        total++; if (busy1 !== 1'b1) $display("FAIL rerun_busy: got %0h want 1", busy1); else passed++;
        total++; if (trst1 !== 1'b0) $display("FAIL rerun_trst: got %0h want 0", trst1); else passed++;
        total++; if (cyc1 !== 32'd2) $display("FAIL rerun_cyc2: got %0d want 2", cyc1); else passed++;
        done1 = 1'b1;
        code1 = 8'h03;
        step();
        done1 = 1'b0;
        code1 = 8'h00;
        total++; if (fin1 !== 1'b1) $display("FAIL rerun_fin: got %0h want 1", fin1); else passed++;
        total++; if (cyc1 !== 32'd3) $display("FAIL rerun_cyc: got %0d want 3", cyc1); else passed++;
        total++; if (fmask1 !== 1'b1) $display("FAIL rerun_fmask: got %0h want 1", fmask1); else passed++;
        total++; if (pass1 !== 1'b0) $display("FAIL rerun_pass: got %0h want 0", pass1); else passed++;
    endtask

    initial begin
        passed = 0;
        total  = 0;
        reset  = 1'b0;
        start1 = 1'b0; done1 = 1'b0; code1 = 8'h00;
        start4 = 1'b0; done4 = 4'h0; code4 = 32'h0;
        start2 = 1'b0; done2 = 2'b00; code2 = 16'h0;
        test_reset();
        test_single();
        test_multi();
        test_timeout();
        test_done_at_limit();
        test_abort_and_rerun();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
